// File: rtl/smsdac_pkg.sv
// Shared constants for the mismatch-shaped unit-element DAC.
//   DATA_W   : width of the input code
//   N_ELEM   : number of unit elements driven (one bit each)
//   N_LEVELS : depth of the switching-block tree (log2 N_ELEM)
//   ACC_W    : width of the first-order delta-sigma residue
//   Y_W      : width of the quantised level count y (0..N_ELEM)
package smsdac_pkg;
  localparam int DATA_W   = 8;
  localparam int N_ELEM   = 16;
  localparam int N_LEVELS = 4;
  localparam int ACC_W    = 4;
  localparam int Y_W      = DATA_W - ACC_W + 1;

  // Input width of a switching block at tree level lv (0 = root).
  // Each level halves the range, so one bit is dropped per level.
  function automatic int lvl_w(input int lv);
    return Y_W - lv;
  endfunction
endpackage

// File: rtl/smsdac_if.sv
// DAC pin bundle as seen from the chip boundary.
//   master : drives the code and the ignored pins, observes element drive
//   slave  : the DAC itself
interface smsdac_if;
  import smsdac_pkg::*;
  logic              ena;
  logic [DATA_W-1:0] ui_in;
  logic [7:0]        uio_in;
  logic [7:0]        uo_out;
  logic [7:0]        uio_out;
  logic [7:0]        uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/sms_switch_block.sv
// One mismatch-shaping switching block.
//   clk, rst_n : clock, async active-low reset
//   n          : number of elements this subtree must turn on
//   A          : count passed to the lower-index subtree
//   B          : count passed to the higher-index subtree
// A+B always equals n. An odd n leaves one spare element; t picks which
// side gets it and flips each time, so both halves are used equally.
module sms_switch_block #(
  parameter int IN_W = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [IN_W-1:0] n,
  output logic [IN_W-2:0] A,
  output logic [IN_W-2:0] B
);
  logic            t;
  logic [IN_W-2:0] half;

  assign half = n[IN_W-1:1];
  assign A    = half + (IN_W-1)'(n[0] & ~t);
  assign B    = half + (IN_W-1)'(n[0] &  t);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    t <= 1'b0;
    else if (n[0]) t <= ~t;
  end
endmodule

// File: rtl/tt_um_ejfogleman_smsdac.sv
// Mismatch-shaped 16-element unit DAC.
//   clk, rst_n : clock, async active-low reset
//   ena        : ignored
//   ui_in      : DAC code x (0..255)
//   uio_in     : ignored
//   uo_out     : element drive e[7:0]
//   uio_out    : element drive e[15:8]
//   uio_oe     : all ones, bidirectional pins are outputs
// x_reg feeds a first-order delta-sigma that reduces the code to a level
// count y (0..16); a binary tree of switching blocks spreads y across the
// elements, and the leaf counts are registered as e.
module tt_um_ejfogleman_smsdac
  import smsdac_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] ui_in,
  input  logic [7:0]        uio_in,
  output logic [7:0]        uo_out,
  output logic [7:0]        uio_out,
  output logic [7:0]        uio_oe
);
  logic [DATA_W-1:0] x_reg;
  logic [ACC_W-1:0]  acc;
  logic [DATA_W:0]   sum;
  logic [Y_W-1:0]    y;
  logic [N_ELEM-1:0] e_nxt, e_q;

  wire unused_pins = &{1'b0, ena, uio_in};

  // 255 + 15 = 270 fits the 9-bit sum, so no saturation is needed.
  assign sum = {1'b0, x_reg} + {{(DATA_W-ACC_W+1){1'b0}}, acc};
  assign y   = sum[DATA_W:ACC_W];

  // Heap-ordered tree: block j at level lv feeds blocks 2j (A) and
  // 2j+1 (B) at level lv+1; the last level's A/B are e[2j], e[2j+1].
  for (genvar lv = 0; lv < N_LEVELS; lv++) begin : lvl
    localparam int W  = lvl_w(lv);
    localparam int NB = 1 << lv;
    logic [W-1:0] n_in [NB];
    logic [W-2:0] a_o  [NB];
    logic [W-2:0] b_o  [NB];

    for (genvar j = 0; j < NB; j++) begin : blk
      if (lv == 0) begin : g_root
        assign n_in[j] = y;
      end else if (j % 2 == 0) begin : g_lo
        assign n_in[j] = lvl[lv-1].a_o[j/2];
      end else begin : g_hi
        assign n_in[j] = lvl[lv-1].b_o[j/2];
      end

      sms_switch_block #(.IN_W(W)) u_sw (
        .clk   (clk),
        .rst_n (rst_n),
        .n     (n_in[j]),
        .A     (a_o[j]),
        .B     (b_o[j])
      );

      if (lv == N_LEVELS-1) begin : g_leaf
        assign e_nxt[2*j]   = a_o[j];
        assign e_nxt[2*j+1] = b_o[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      acc   <= '0;
      e_q   <= '0;
    end else begin
      x_reg <= ui_in;
      acc   <= sum[ACC_W-1:0];
      e_q   <= e_nxt;
    end
  end

  assign uo_out  = e_q[7:0];
  assign uio_out = e_q[15:8];
  assign uio_oe  = 8'hFF;
endmodule

// File: tb/tb_tt_um_ejfogleman_smsdac.sv
// Scoreboard bench for the mismatch-shaped DAC: the stimulus process steps
// a reference model and queues the expected element drive for each edge;
// the monitor pops one entry per cycle on the falling edge and compares.
module tb_tt_um_ejfogleman_smsdac;
  import smsdac_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  smsdac_if bus ();

  tt_um_ejfogleman_smsdac dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (bus.ena),
    .ui_in   (bus.ui_in),
    .uio_in  (bus.uio_in),
    .uo_out  (bus.uo_out),
    .uio_out (bus.uio_out),
    .uio_oe  (bus.uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] e;      // model expectation {uio_out, uo_out}
    int          y;      // model level count
    bit          hand;   // hand-computed e present
    logic [15:0] he;
    int          hy;     // hand-computed y, -1 if none
    int          ph;     // 1 = counted in full-scale window
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0, n_fail = 0;
  int fs_sum = 0;

  // reference model state
  int   xm, accm;
  bit   tm [15];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    xm = 0; accm = 0;
    for (int i = 0; i < 15; i++) tm[i] = 1'b0;
  endtask

  // Drive one code, advance the model by one edge, queue the expectation.
  task automatic step(input logic [7:0] code, input bit hand,
                      input logic [15:0] he, input int hy, input int ph);
    exp_t it;
    int   nd [31];
    int   s;
    bus.ui_in = code;
    s    = xm + accm;
    nd[0] = s / 16;
    accm = s % 16;
    xm   = code;
    for (int i = 0; i < 15; i++) begin
      int a;
      a = nd[i] / 2 + (((nd[i] % 2) == 1 && !tm[i]) ? 1 : 0);
      nd[2*i+1] = a;
      nd[2*i+2] = nd[i] - a;
      if ((nd[i] % 2) == 1) tm[i] = ~tm[i];
    end
    for (int k = 0; k < 16; k++) it.e[k] = (nd[15+k] != 0);
    it.y = nd[0]; it.hand = hand; it.he = he; it.hy = hy; it.ph = ph;
    @(posedge clk);
    sbq.push_back(it);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    bus.ui_in = 8'hFF;
    model_reset();
    #1;
    chk("rst_uo_async", bus.uo_out, 0);
    chk("rst_uio_async", bus.uio_out, 0);
    chk("rst_oe_async", bus.uio_oe, 8'hFF);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uo_held", bus.uo_out, 0);
    chk("rst_uio_held", bus.uio_out, 0);
    chk("rst_oe_held", bus.uio_oe, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int k = 0; k < 4 && sbq.size() > 0; k++) @(negedge clk);
    #1;
    chk("scoreboard_drained", sbq.size(), 0);
  endtask

  // monitor
  initial begin
    exp_t it;
    logic [15:0] act;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        it  = sbq.pop_front();
        act = {bus.uio_out, bus.uo_out};
        chk("model_e", act, it.e);
        chk("popcount_y", $countones(act), it.y);
        chk("uio_oe", bus.uio_oe, 8'hFF);
        if (it.hand) chk("hand_e", act, it.he);
        if (it.hy >= 0) chk("hand_y", $countones(act), it.hy);
        if (it.ph == 1) fs_sum += $countones(act);
      end
    end
  end

  // small-code expectations {uio_out, uo_out}, one per edge after reset
  logic [15:0] small_tbl [9] = '{16'h0000, 16'h0000, 16'h0001, 16'h0000,
                                 16'h0100, 16'h0000, 16'h0010, 16'h0000,
                                 16'h1000};

  initial begin
    int d;
    bus.ena = 1'b1;
    bus.uio_in = 8'h5A;
    bus.ui_in = 8'hFF;
    model_reset();

    do_reset();

    // zero code
    for (int k = 0; k < 50; k++) step(8'd0, 1'b1, 16'h0000, 0, 0);

    // mid-scale: first edge still sees x_reg=0, then 55/AA alternation
    do_reset();
    step(8'd128, 1'b1, 16'h0000, 0, 0);
    for (int k = 1; k <= 8; k++)
      step(8'd128, 1'b1, (k % 2) ? 16'h5555 : 16'hAAAA, 8, 0);

    // small code: single element, rotating through the tree
    do_reset();
    for (int k = 0; k < 9; k++) step(8'd8, 1'b1, small_tbl[k], -1, 0);

    // full scale: 256-cycle window starts once x_reg holds 255
    do_reset();
    fs_sum = 0;
    step(8'd255, 1'b1, 16'h0000, 0, 0);
    step(8'd255, 1'b0, 16'h0000, 15, 1);
    step(8'd255, 1'b0, 16'h0000, 16, 1);
    for (int k = 2; k < 256; k++) step(8'd255, 1'b0, 16'h0000, -1, 1);
    drain();
    d = fs_sum - 255 * 16;
    if (d < 0) d = -d;
    n_chk++;
    if (d > 16) begin
      n_fail++;
      $display("FAIL fs_window_sum: got %0d expected %0d +/- 16", fs_sum, 255 * 16);
    end

    // random codes with a reset pulse mid-run
    for (int k = 0; k < 60; k++) step(8'($urandom_range(0, 255)), 1'b0, 16'h0, -1, 0);
    do_reset();
    for (int k = 0; k < 60; k++) step(8'($urandom_range(0, 255)), 1'b0, 16'h0, -1, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
